// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller.
// FSM state, register width and the pipe_ctrl bundle.
package pipeline_pkg;

  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
    id_ex_en: 1'b1, id_ex_flush: 1'b0,
    ex_mem_en: 1'b1, mem_wb_flush: 1'b0
  };

  localparam pipe_ctrl_t CTRL_RESET = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
    id_ex_en: 1'b0, id_ex_flush: 1'b1,
    ex_mem_en: 1'b0, mem_wb_flush: 1'b1
  };

  localparam pipe_ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
    id_ex_en: 1'b0, id_ex_flush: 1'b0,
    ex_mem_en: 1'b0, mem_wb_flush: 1'b1
  };

  localparam pipe_ctrl_t CTRL_BRANCH = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
    id_ex_en: 1'b1, id_ex_flush: 1'b1,
    ex_mem_en: 1'b1, mem_wb_flush: 1'b0
  };

  localparam pipe_ctrl_t CTRL_LOAD_USE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
    id_ex_en: 1'b1, id_ex_flush: 1'b1,
    ex_mem_en: 1'b1, mem_wb_flush: 1'b0
  };

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: ID source vs EX load dest.
// Ports: rn/rm addrs + use bits, ex_rd_addr, ex_mem_read -> load_use.
module hazard_detect #(
  parameter int W = 4
) (
  input  logic [W-1:0] id_rn_addr,
  input  logic [W-1:0] id_rm_addr,
  input  logic         id_uses_rn,
  input  logic         id_uses_rm,
  input  logic [W-1:0] ex_rd_addr,
  input  logic         ex_mem_read,
  output logic         load_use
);

  logic rn_hit;
  logic rm_hit;

  assign rn_hit = id_uses_rn && (id_rn_addr == ex_rd_addr);
  assign rm_hit = id_uses_rm && (id_rm_addr == ex_rd_addr);
  assign load_use = ex_mem_read && (rn_hit || rm_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: memory wait > taken branch > load-use.
// Ports: hazard inputs in, stage enables/flushes, stall count, timeout out.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
  parameter int MAX_WAIT   = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rn_addr,
  input  logic [REG_ADDR_W-1:0] id_rm_addr,
  input  logic                  id_uses_rn,
  input  logic                  id_uses_rm,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_enable,
  output logic                  if_id_enable,
  output logic                  if_id_flush,
  output logic                  id_ex_enable,
  output logic                  id_ex_flush,
  output logic                  ex_mem_enable,
  output logic                  mem_wb_flush,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  mem_timeout
);

  import pipeline_pkg::*;

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(MAX_WAIT);

  hz_state_e         state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic       load_use;
  logic       mem_wait;
  logic       stall_ev;
  pipe_ctrl_t ctrl;

  hazard_detect #(
    .W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_rn_addr  (id_rn_addr),
    .id_rm_addr  (id_rm_addr),
    .id_uses_rn  (id_uses_rn),
    .id_uses_rm  (id_uses_rm),
    .ex_rd_addr  (ex_rd_addr),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_wait = mem_req && !mem_ready;

  // Output mux; reset and ERROR dominate everything else.
  always_comb begin
    ctrl = CTRL_RUN;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else if (state_q == ERROR || mem_wait) begin
      ctrl = CTRL_FREEZE;
    end else if (ex_branch_taken) begin
      ctrl = CTRL_BRANCH;
    end else if (load_use) begin
      ctrl = CTRL_LOAD_USE;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_ev      = 1'b0;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_wait) begin
          stall_ev   = 1'b1;
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_d >= WAIT_LIM) begin
            state_d       = ERROR;
            mem_timeout_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          // A branch squashes the stalled instruction; not a stall.
          stall_ev   = load_use && !ex_branch_taken;
        end
      end
      ERROR: begin
        stall_ev = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_ev && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      mem_timeout_q  <= mem_timeout_d;
    end
  end

  assign pc_enable     = ctrl.pc_en;
  assign if_id_enable  = ctrl.if_id_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_enable  = ctrl.id_ex_en;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_enable = ctrl.ex_mem_en;
  assign mem_wb_flush  = ctrl.mem_wb_flush;
  assign stall_cycles  = stall_cycles_q;
  assign mem_timeout   = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed plan then random stimulus.
// Expected values come from a rule-level model held in this file.
module tb_pipeline_hazard_ctrl;

  localparam int AW       = 4;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 5;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] id_rn_addr, id_rm_addr, ex_rd_addr;
  logic          id_uses_rn, id_uses_rm;
  logic          ex_mem_read, ex_branch_taken;
  logic          mem_req, mem_ready;
  logic          pc_enable, if_id_enable, if_id_flush;
  logic          id_ex_enable, id_ex_flush;
  logic          ex_mem_enable, mem_wb_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic          mem_timeout;

  int checks = 0;
  int errors = 0;

  // Model state: consecutive waits seen, error flag, stall total.
  int m_waits = 0;
  bit m_err   = 0;
  int m_stall = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W (AW),
    .MAX_WAIT   (MAX_WAIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rn_addr      (id_rn_addr),
    .id_rm_addr      (id_rm_addr),
    .id_uses_rn      (id_uses_rn),
    .id_uses_rm      (id_uses_rm),
    .ex_rd_addr      (ex_rd_addr),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_enable       (pc_enable),
    .if_id_enable    (if_id_enable),
    .if_id_flush     (if_id_flush),
    .id_ex_enable    (id_ex_enable),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_enable   (ex_mem_enable),
    .mem_wb_flush    (mem_wb_flush),
    .stall_cycles    (stall_cycles),
    .mem_timeout     (mem_timeout)
  );

  // One cycle: drive, check mid-cycle, advance model, cross edge.
  task automatic step(
    input logic          r,
    input logic [AW-1:0] rn,
    input logic [AW-1:0] rm,
    input logic          urn,
    input logic          urm,
    input logic [AW-1:0] rd,
    input logic          mr,
    input logic          br,
    input logic          mq,
    input logic          my,
    input string         tag
  );
    logic [6:0] exp_v;
    logic [6:0] obs_v;
    bit lu;
    bit waiting;
    reset = r; id_rn_addr = rn; id_rm_addr = rm;
    id_uses_rn = urn; id_uses_rm = urm; ex_rd_addr = rd;
    ex_mem_read = mr; ex_branch_taken = br;
    mem_req = mq; mem_ready = my;
    @(negedge clk);
    lu = mr && ((urn && rn == rd) || (urm && rm == rd));
    waiting = mq && !my;
    // {pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, mem_wb_fl}
    if (r)                    exp_v = 7'b0010101;
    else if (m_err || waiting) exp_v = 7'b0000001;
    else if (br)              exp_v = 7'b1111110;
    else if (lu)              exp_v = 7'b0001110;
    else                      exp_v = 7'b1101010;
    obs_v = {pc_enable, if_id_enable, if_id_flush, id_ex_enable,
             id_ex_flush, ex_mem_enable, mem_wb_flush};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s ctrl: got %b want %b", tag, obs_v, exp_v);
    end
    checks++;
    assert (stall_cycles === CNT_W'(m_stall)) else begin
      errors++;
      $error("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cycles, m_stall);
    end
    checks++;
    assert (mem_timeout === m_err) else begin
      errors++;
      $error("FAIL %s mem_timeout: got %b want %b", tag, mem_timeout, m_err);
    end
    if (r) begin
      m_waits = 0; m_err = 0; m_stall = 0;
    end else if (m_err) begin
      m_stall++;
    end else if (waiting) begin
      m_waits++;
      m_stall++;
      if (m_waits == MAX_WAIT) m_err = 1;
    end else begin
      m_waits = 0;
      if (lu && !br) m_stall++;
    end
    if (m_stall > SAT) m_stall = SAT;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    reset = 1; id_rn_addr = 0; id_rm_addr = 0; ex_rd_addr = 0;
    id_uses_rn = 0; id_uses_rm = 0; ex_mem_read = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset1");
    idle("post_reset");

    step(0, 3, 0, 1, 0, 3, 1, 0, 0, 0, "load_use");
    idle("after_lu");
    checks++;
    assert (stall_cycles === CNT_W'(1)) else begin
      errors++;
      $error("FAIL lu_count: got %0d want 1", stall_cycles);
    end

    step(0, 3, 0, 0, 0, 3, 1, 0, 0, 0, "no_false_stall");
    step(0, 0, 5, 0, 1, 5, 1, 0, 0, 0, "load_use_rm");
    step(0, 7, 7, 1, 1, 7, 1, 1, 0, 0, "branch_lu");
    idle("after_branch");

    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, "mem_wait");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, "mem_ready_br");
    idle("after_wait");
    checks++;
    assert (stall_cycles === CNT_W'(5)) else begin
      errors++;
      $error("FAIL wait_count: got %0d want 5", stall_cycles);
    end

    for (int i = 0; i < MAX_WAIT; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "to_wait");
    checks++;
    assert (mem_timeout === 1'b1) else begin
      errors++;
      $error("FAIL timeout_set: got %b want 1", mem_timeout);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, "err_ready");
    step(0, 2, 0, 1, 0, 2, 1, 0, 0, 0, "err_lu");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "err_reset");
    idle("err_cleared");

    for (int i = 0; i < 25; i++)
      step(0, 1, 0, 1, 0, 1, 1, 0, 0, 0, "saturate");

    for (int i = 0; i < 600; i++) begin
      logic r, mq, my;
      r  = ($urandom_range(0, 39) == 0);
      mq = ($urandom_range(0, 2) == 0);
      my = ($urandom_range(0, 2) != 0);
      step(r,
           AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom),
           AW'($urandom_range(0, 3)),
           1'($urandom), ($urandom_range(0, 3) == 0),
           mq, my, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
